// File: rtl/remote_comm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : remote_comm_pkg
// Description : Shared types and constants for the host-side command sender
//               (remote_comm) and its UART transceiver.
// Revision    : 1.0 - initial release
// ============================================================================
package remote_comm_pkg;

  // Command/response sequencer states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TX_HI     = 2'd1,
    TX_LO     = 2'd2,
    WAIT_RESP = 2'd3
  } rc_state_t;

  // Response codes the robot is known to return
  localparam logic [7:0] RESP_ACK     = 8'hA5;
  localparam logic [7:0] RESP_POS_ACK = 8'h5A;

  // Default response window in clk cycles
  localparam int DEF_TIMEOUT = 1_000_000;

  // Default clocks per serial bit (50 MHz / 19200 baud)
  localparam int DEF_BAUD_DIV = 2604;

endpackage : remote_comm_pkg
`default_nettype wire

// File: rtl/remote_comm_uart.sv
`default_nettype none
// ============================================================================
// Module      : remote_comm_uart
// Description : 8N1 UART transceiver. The transmitter sends one byte per
//               trmt pulse and raises tx_done at the end of the stop bit
//               (cleared by the next trmt). The receiver oversamples at bit
//               centres and holds rx_rdy until clr_rx_rdy.
// Revision    : 1.0 - initial release
// ============================================================================
module remote_comm_uart #(
  parameter int BAUD_DIV = 2604   // clk cycles per bit, must be >= 4
) (
  input  logic       clk,
  input  logic       rst_n,
  // transmit side
  input  logic       trmt_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_o,
  output logic       tx_done_o,
  // receive side
  input  logic       rx_i,
  input  logic       clr_rx_rdy_i,
  output logic [7:0] rx_data_o,
  output logic       rx_rdy_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  // ---------------------------------------------------------------- transmit
  logic [9:0]    tx_shift_q;   // {stop, data[7:0], start}, LSB on the wire
  logic [CW-1:0] tx_baud_q;
  logic [3:0]    tx_bits_q;
  logic          tx_busy_q;
  logic          tx_done_q;

  // Frame shifter: an all-ones shift register keeps the line idle-high, and a
  // reset mid-frame simply reloads ones, aborting the frame with TX=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= '1;
      tx_baud_q  <= '0;
      tx_bits_q  <= '0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else if (trmt_i) begin
      tx_shift_q <= {1'b1, tx_data_i, 1'b0};
      tx_baud_q  <= '0;
      tx_bits_q  <= '0;
      tx_busy_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else if (tx_busy_q) begin
      if (tx_baud_q == BIT_LAST) begin
        tx_baud_q <= '0;
        if (tx_bits_q == 4'd9) begin
          tx_busy_q  <= 1'b0;
          tx_done_q  <= 1'b1;
          tx_shift_q <= '1;
        end else begin
          tx_bits_q  <= tx_bits_q + 4'd1;
          tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        end
      end else begin
        tx_baud_q <= tx_baud_q + CW'(1);
      end
    end
  end

  assign tx_o      = tx_shift_q[0];
  assign tx_done_o = tx_done_q;

  // ----------------------------------------------------------------- receive
  logic          rx_meta_q, rx_sync_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bits_q;   // 0 = start, 1..8 = data, 9 = stop
  logic          rx_busy_q;
  logic [7:0]    rx_shift_q;
  logic          rx_rdy_q;

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver: half a bit to the start-bit centre, then whole bits to each
  // data centre; a high start sample is treated as noise and ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_q   <= '0;
      rx_bits_q  <= '0;
      rx_busy_q  <= 1'b0;
      rx_shift_q <= '0;
      rx_rdy_q   <= 1'b0;
    end else begin
      if (clr_rx_rdy_i) begin
        rx_rdy_q <= 1'b0;
      end
      if (!rx_busy_q) begin
        if (!rx_sync_q) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= HALF_LAST;
          rx_bits_q <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - CW'(1);
      end else begin
        rx_cnt_q <= BIT_LAST;
        if (rx_bits_q == 4'd0) begin
          if (rx_sync_q) begin
            rx_busy_q <= 1'b0;
          end else begin
            rx_bits_q <= 4'd1;
          end
        end else if (rx_bits_q == 4'd9) begin
          rx_busy_q <= 1'b0;
          if (rx_sync_q) begin
            rx_rdy_q <= 1'b1;   // a completed frame outranks a same-cycle clear
          end
        end else begin
          rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
          rx_bits_q  <= rx_bits_q + 4'd1;
        end
      end
    end
  end

  assign rx_data_o = rx_shift_q;
  assign rx_rdy_o  = rx_rdy_q;

endmodule : remote_comm_uart
`default_nettype wire

// File: rtl/remote_comm.sv
`default_nettype none
// ============================================================================
// Module      : remote_comm
// Description : Host-side command sender. Serialises a 16-bit command as two
//               UART bytes (high byte first), then waits for a one-byte
//               response from the robot, capturing it or flagging a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,   // must be >= 2
  parameter int BAUD_DIV       = DEF_BAUD_DIV,  // clk cycles per bit
  localparam int TO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd_i,
  input  logic [15:0] cmd_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        cmd_snt_o,
  output logic [7:0]  resp_o,
  output logic        resp_rdy_o,
  output logic        resp_timeout_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  rc_state_t       state_q;
  logic [7:0]      cmd_lo_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            busy_q;
  logic            cmd_snt_q;
  logic [7:0]      resp_q;
  logic            resp_rdy_q;
  logic            resp_timeout_q;

  logic            trmt;
  logic [7:0]      tx_data;
  logic            tx_done;
  logic            clr_rx_rdy;
  logic [7:0]      rx_data;
  logic            rx_rdy;

  remote_comm_uart #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk          (clk),
    .rst_n        (rst_n),
    .trmt_i       (trmt),
    .tx_data_i    (tx_data),
    .tx_o         (tx_o),
    .tx_done_o    (tx_done),
    .rx_i         (rx_i),
    .clr_rx_rdy_i (clr_rx_rdy),
    .rx_data_o    (rx_data),
    .rx_rdy_o     (rx_rdy)
  );

  // UART strobes: the high byte goes straight from cmd_i in the accept cycle,
  // the low byte from the latch. Every received byte is acknowledged at once;
  // only WAIT_RESP keeps it, so bytes arriving in any other state are dropped.
  always_comb begin
    trmt       = 1'b0;
    tx_data    = cmd_i[15:8];
    clr_rx_rdy = rx_rdy;
    case (state_q)
      IDLE:    trmt = snd_cmd_i;
      TX_HI: begin
        trmt    = tx_done;
        tx_data = cmd_lo_q;
      end
      default: ;
    endcase
  end

  // Sequencer with its registered status flags and response window counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cmd_lo_q       <= '0;
      to_cnt_q       <= '0;
      busy_q         <= 1'b0;
      cmd_snt_q      <= 1'b0;
      resp_q         <= '0;
      resp_rdy_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (snd_cmd_i) begin
            cmd_lo_q       <= cmd_i[7:0];
            cmd_snt_q      <= 1'b0;
            resp_rdy_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= TX_HI;
          end
        end
        TX_HI: begin
          if (tx_done) begin
            state_q <= TX_LO;
          end
        end
        TX_LO: begin
          if (tx_done) begin
            cmd_snt_q <= 1'b1;
            to_cnt_q  <= '0;
            state_q   <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // A byte landing on the terminal count still counts as a response
          if (rx_rdy) begin
            resp_q     <= rx_data;
            resp_rdy_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (to_cnt_q == TO_LAST) begin
            resp_timeout_q <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign cmd_snt_o      = cmd_snt_q;
  assign resp_o         = resp_q;
  assign resp_rdy_o     = resp_rdy_q;
  assign resp_timeout_o = resp_timeout_q;

endmodule : remote_comm
`default_nettype wire
